// File: rtl/uart_port_fifo.sv
// 16550-lite UART register window on the CPU port bus with RX/TX FIFOs,
// sticky overrun, a three-state transmit launcher and a registered interrupt.
module uart_port_fifo #(
  parameter logic [11:0] BASE_ADDR = 12'h3F8,
  parameter int          RX_DEPTH  = 16,
  parameter int          TX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] port_addr,
  input  logic        ReadReq,
  input  logic        WriteReq,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        DataValid,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_recv,
  output logic        irq
);

  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL = RX_DEPTH[RXA:0];
  localparam logic [TXA:0] TX_FULL = TX_DEPTH[TXA:0];

  typedef enum logic [1:0] {IDLE, START, HOLD} tx_state_t;

  tx_state_t    tx_state, tx_state_nxt;
  logic         req_q;
  logic [1:0]   ier, ier_nxt;
  logic [7:0]   scr;
  logic         oe, oe_nxt, oe_set;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wp, rx_rp;
  logic [RXA:0] rx_count, rx_count_nxt;
  logic         rx_push, rx_pop, rx_full;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wp, tx_rp;
  logic [TXA:0] tx_count, tx_count_nxt;
  logic         tx_push, tx_go, tx_full;
  logic [7:0]   tx_head;

  logic [11:0]  offset;
  logic         in_win, txn, rd_en, wr_en;
  logic         sel_rbr, sel_ier, sel_lsr, sel_scr;
  logic         dr, thre, temt;
  logic [7:0]   iir, lsr, rd_byte;
  logic         unused_bits;

  assign unused_bits = ^write_data[31:8];

  // Decode: a transaction is the first cycle of a request level.
  assign offset  = port_addr - BASE_ADDR;
  assign in_win  = (offset < 12'd8);
  assign txn     = (ReadReq | WriteReq) & ~req_q;
  assign rd_en   = txn & ReadReq;
  assign wr_en   = txn & WriteReq & ~ReadReq;
  assign sel_rbr = in_win & (offset[2:0] == 3'd0);
  assign sel_ier = in_win & (offset[2:0] == 3'd1);
  assign sel_lsr = in_win & (offset[2:0] == 3'd5);
  assign sel_scr = in_win & (offset[2:0] == 3'd7);

  // Status and register read mux (pre-update view of state).
  assign dr   = (rx_count != '0);
  assign thre = (tx_count == '0);
  assign temt = thre & ~uart_tx_busy & (tx_state == IDLE);
  assign lsr  = {1'b0, temt, thre, 3'b000, oe, dr};
  assign iir  = (ier[0] & dr)   ? 8'h04 :
                (ier[1] & thre) ? 8'h02 : 8'h01;

  always_comb begin
    rd_byte = 8'h00;
    if (in_win) begin
      case (offset[2:0])
        3'd0:    rd_byte = dr ? rx_mem[rx_rp] : 8'h00;
        3'd1:    rd_byte = {6'b0, ier};
        3'd2:    rd_byte = iir;
        3'd5:    rd_byte = lsr;
        3'd7:    rd_byte = scr;
        default: rd_byte = 8'h00;
      endcase
    end
  end

  // RX FIFO: a full FIFO still accepts a byte when the head leaves the same cycle.
  assign rx_full      = (rx_count == RX_FULL);
  assign rx_pop       = rd_en & sel_rbr & dr;
  assign rx_push      = uart_rx_recv & (~rx_full | rx_pop);
  assign oe_set       = uart_rx_recv & rx_full & ~rx_pop;
  assign oe_nxt       = oe_set | (oe & ~(rd_en & sel_lsr));
  assign rx_count_nxt = rx_count + {{RXA{1'b0}}, rx_push} - {{RXA{1'b0}}, rx_pop};

  // TX FIFO: a THR write into an empty FIFO can launch in the same cycle.
  assign tx_full      = (tx_count == TX_FULL);
  assign tx_push      = wr_en & sel_rbr & ~tx_full;
  assign tx_go        = (tx_state == IDLE) & ~uart_tx_busy & (~thre | tx_push);
  assign tx_head      = thre ? write_data[7:0] : tx_mem[tx_rp];
  assign tx_count_nxt = tx_count + {{TXA{1'b0}}, tx_push} - {{TXA{1'b0}}, tx_go};

  assign ier_nxt = (wr_en & sel_ier) ? write_data[1:0] : ier;

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      IDLE:    if (tx_go) tx_state_nxt = START;
      START:   tx_state_nxt = HOLD;
      HOLD:    tx_state_nxt = IDLE;
      default: tx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
    if (tx_push) tx_mem[tx_wp] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q         <= 1'b0;
      DataValid     <= 1'b0;
      read_data     <= 32'h0;
      ier           <= 2'b00;
      scr           <= 8'h00;
      oe            <= 1'b0;
      rx_wp         <= '0;
      rx_rp         <= '0;
      rx_count      <= '0;
      tx_wp         <= '0;
      tx_rp         <= '0;
      tx_count      <= '0;
      tx_state      <= IDLE;
      uart_tx_data  <= 8'h00;
      uart_tx_start <= 1'b0;
      irq           <= 1'b0;
    end else begin
      req_q     <= ReadReq | WriteReq;
      DataValid <= ReadReq | WriteReq;
      if (rd_en) read_data <= {24'h0, rd_byte};
      ier <= ier_nxt;
      if (wr_en & sel_scr) scr <= write_data[7:0];
      oe <= oe_nxt;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_count <= rx_count_nxt;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_go)   tx_rp <= tx_rp + 1'b1;
      tx_count <= tx_count_nxt;
      tx_state <= tx_state_nxt;
      if (tx_go) uart_tx_data <= tx_head;
      uart_tx_start <= tx_go;
      irq <= (ier_nxt[0] & (rx_count_nxt != '0)) | (ier_nxt[1] & (tx_count_nxt == '0));
    end
  end

endmodule

// File: tb/tb_uart_port_fifo.sv
// Bench for uart_port_fifo: bus-level register accesses, a busy-modelling
// transmitter and queue-based reference model of the FIFOs and status bits.
module tb_uart_port_fifo;

  localparam int          RXD  = 16;
  localparam logic [11:0] BASE = 12'h3F8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] port_addr = 12'h0;
  logic        ReadReq = 1'b0;
  logic        WriteReq = 1'b0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        DataValid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy = 1'b0;
  logic [7:0]  uart_rx_data = 8'h0;
  logic        uart_rx_recv = 1'b0;
  logic        irq;

  uart_port_fifo #(.BASE_ADDR(BASE), .RX_DEPTH(RXD), .TX_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .port_addr(port_addr), .ReadReq(ReadReq),
    .WriteReq(WriteReq), .write_data(write_data), .read_data(read_data),
    .DataValid(DataValid), .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data), .uart_rx_recv(uart_rx_recv),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int busy_len = 10;
  int pulses = 0;
  logic prev_start = 1'b0;
  logic [7:0] tx_seen[$];
  logic [7:0] rxq[$];
  logic       oe_m = 1'b0;

  // Transmitter model: busy for busy_len cycles after each start pulse.
  initial forever begin
    @(posedge clk); #1;
    if (busy_cnt > 0) busy_cnt--;
    if (uart_tx_start === 1'b1) begin
      pulses++;
      tx_seen.push_back(uart_tx_data);
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_gap: start pulses in consecutive cycles, data=%h", uart_tx_data);
      end
      busy_cnt = busy_len;
    end
    prev_start = (uart_tx_start === 1'b1);
    uart_tx_busy = (busy_cnt != 0);
  end

  task automatic wait_ack();
    int n = 0;
    do begin @(negedge clk); n++; end while (DataValid !== 1'b1 && n < 20);
    checks++;
    if (DataValid !== 1'b1) begin
      errors++;
      $display("FAIL bus_ack: DataValid=%b after %0d cycles, required 1", DataValid, n);
    end
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    port_addr = a; ReadReq = 1'b1;
    wait_ack();
    d = read_data;
    ReadReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [7:0] v);
    @(negedge clk);
    port_addr = a; write_data = {24'hABCDEF, v}; WriteReq = 1'b1;
    wait_ack();
    WriteReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_data = b; uart_rx_recv = 1'b1;
    if (rxq.size() < RXD) rxq.push_back(b); else oe_m = 1'b1;
    @(negedge clk);
    uart_rx_recv = 1'b0;
  endtask

  function automatic logic [7:0] model_pop();
    if (rxq.size() == 0) return 8'h00;
    return rxq.pop_front();
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({read_data, DataValid, irq, uart_tx_start, uart_tx_data} !== 43'h0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%h dv=%b irq=%b start=%b txd=%h, required all 0",
               read_data, DataValid, irq, uart_tx_start, uart_tx_data);
    end
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== 32'h60) begin errors++; $display("FAIL reset_lsr: got %h required 00000060", d); end
    bus_read(BASE + 12'd2, d);
    checks++;
    if (d !== 32'h01) begin errors++; $display("FAIL reset_iir: got %h required 00000001", d); end
    checks++;
    if (irq !== 1'b0 || pulses != 0) begin
      errors++;
      $display("FAIL reset_idle: irq=%b pulses=%0d required 0 and 0", irq, pulses);
    end
  endtask

  task automatic test_rx_order();
    logic [31:0] d;
    logic [7:0]  e;
    rx_byte(8'hA1); rx_byte(8'hA2); rx_byte(8'hA3);
    for (int i = 0; i < 4; i++) begin
      e = model_pop();
      bus_read(BASE, d);
      checks++;
      if (d !== {24'h0, e}) begin errors++; $display("FAIL rbr_order[%0d]: got %h required %h", i, d, e); end
      if (i == 2) begin
        bus_read(BASE + 12'd5, d);
        checks++;
        if (d !== 32'h60) begin errors++; $display("FAIL lsr_dr_clear: got %h required 00000060", d); end
      end
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  e;
    for (int i = 0; i <= RXD; i++) rx_byte(8'($urandom));
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== {24'h0, 6'b011000, oe_m, 1'b1}) begin errors++; $display("FAIL lsr_overrun: got %h required 00000063", d); end
    oe_m = 1'b0;
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== 32'h61) begin errors++; $display("FAIL lsr_oe_clear: got %h required 00000061", d); end
    for (int i = 0; i < RXD; i++) begin
      e = model_pop();
      bus_read(BASE, d);
      checks++;
      if (d !== {24'h0, e}) begin errors++; $display("FAIL overrun_data[%0d]: got %h required %h", i, d, e); end
    end
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== 32'h60) begin errors++; $display("FAIL overrun_drained: got %h required 00000060", d); end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    int n;
    tx_seen.delete();
    bus_write(BASE, 8'h41);
    bus_write(BASE, 8'h42);
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== 32'h00) begin errors++; $display("FAIL lsr_tx_pending: got %h required 00000000", d); end
    n = 0;
    while (tx_seen.size() < 2 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (tx_seen.size() != 2 || tx_seen[0] !== 8'h41 || tx_seen[1] !== 8'h42) begin
      errors++;
      $display("FAIL tx_data: got %0d pulses first=%h second=%h required 2 pulses 41 42",
               tx_seen.size(), tx_seen.size() > 0 ? tx_seen[0] : 8'h00,
               tx_seen.size() > 1 ? tx_seen[1] : 8'h00);
    end
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== 32'h20) begin errors++; $display("FAIL lsr_temt_busy: got %h required 00000020", d); end
    n = 0;
    while (uart_tx_busy && n < 50) begin @(negedge clk); n++; end
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== 32'h60) begin errors++; $display("FAIL lsr_temt_idle: got %h required 00000060", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(BASE + 12'd1, 8'hFF);
    bus_read(BASE + 12'd1, d);
    checks++;
    if (d !== 32'h03) begin errors++; $display("FAIL ier_readback: got %h required 00000003", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_thre: got %b required 1", irq); end
    bus_read(BASE + 12'd2, d);
    checks++;
    if (d !== 32'h02) begin errors++; $display("FAIL iir_thre: got %h required 00000002", d); end
    rx_byte(8'h5A);
    bus_read(BASE + 12'd2, d);
    checks++;
    if (d !== 32'h04) begin errors++; $display("FAIL iir_rda: got %h required 00000004", d); end
    bus_read(BASE, d);
    checks++;
    if (d !== {24'h0, model_pop()}) begin errors++; $display("FAIL irq_rbr: got %h required 0000005a", d); end
    bus_read(BASE + 12'd2, d);
    checks++;
    if (d !== 32'h02) begin errors++; $display("FAIL iir_back: got %h required 00000002", d); end
    bus_write(BASE + 12'd1, 8'h01);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_off: got %b required 0", irq); end
    rx_byte(8'hC3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_n1: got %b required 1", irq); end
    bus_read(BASE, d);
    checks++;
    if (d !== {24'h0, model_pop()} || irq !== 1'b0) begin
      errors++; $display("FAIL irq_rx_clear: data=%h irq=%b required 000000c3 and 0", d, irq);
    end
    bus_write(BASE + 12'd1, 8'h00);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  v, e;
    int n;
    for (int r = 0; r < 3; r++) begin
      v = 8'($urandom);
      bus_write(BASE + 12'd7, v);
      bus_read(BASE + 12'd7, d);
      checks++;
      if (d !== {24'h0, v}) begin errors++; $display("FAIL scr[%0d]: got %h required %h", r, d, v); end
      n = $urandom_range(1, RXD);
      for (int i = 0; i < n; i++) begin
        rx_byte(8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int i = 0; i <= n; i++) begin
        e = model_pop();
        bus_read(BASE, d);
        checks++;
        if (d !== {24'h0, e}) begin errors++; $display("FAIL rand_rbr[%0d][%0d]: got %h required %h", r, i, d, e); end
      end
    end
    bus_write(BASE + 12'd3, 8'hFF);
    bus_read(BASE + 12'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reg3: got %h required 00000000", d); end
    bus_read(12'h100, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL outside: got %h required 00000000", d); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    int snap;
    busy_len = 40;
    for (int i = 0; i < 5; i++) bus_write(BASE, 8'h10 + 8'(i));
    @(negedge clk);
    reset = 1'b1; uart_rx_recv = 1'b1; uart_rx_data = 8'h99; busy_cnt = 0;
    @(negedge clk);
    reset = 1'b0; uart_rx_recv = 1'b0;
    rxq.delete(); oe_m = 1'b0; busy_len = 10;
    snap = pulses;
    repeat (5) @(negedge clk);
    checks++;
    if (pulses != snap) begin errors++; $display("FAIL reset_no_start: got %0d pulses required 0", pulses - snap); end
    bus_read(BASE + 12'd5, d);
    checks++;
    if (d !== 32'h60) begin errors++; $display("FAIL reset_mid_lsr: got %h required 00000060", d); end
    bus_read(BASE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mid_rbr: got %h required 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_rx_order();
    test_rx_overrun();
    test_tx();
    test_irq();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
